// File: rtl/ic_tester_pkg.sv
// Shared gate codes and golden truth-table constants for the IC tester.
package ic_tester_pkg;

    typedef logic [2:0] gate_sel_t;

    localparam int unsigned NUM_IN   = 3;
    localparam int unsigned NUM_GATE = 6;

    localparam gate_sel_t GATE_AND  = 3'b000;
    localparam gate_sel_t GATE_OR   = 3'b001;
    localparam gate_sel_t GATE_NAND = 3'b010;
    localparam gate_sel_t GATE_NOR  = 3'b011;
    localparam gate_sel_t GATE_XOR  = 3'b100;
    localparam gate_sel_t GATE_XNOR = 3'b101;

    // Bit i is the gate output for A=i[0], B=i[1], C=i[2].
    localparam logic [7:0] TT_AND  = 8'h80;
    localparam logic [7:0] TT_OR   = 8'hFE;
    localparam logic [7:0] TT_NAND = 8'h7F;
    localparam logic [7:0] TT_NOR  = 8'h01;
    localparam logic [7:0] TT_XOR  = 8'h96;
    localparam logic [7:0] TT_XNOR = 8'h69;

    function automatic logic [7:0] truth_table_of(gate_sel_t sel);
        logic [7:0] tt;
        tt = 8'h00;
        case (sel)
            GATE_AND:  tt = TT_AND;
            GATE_OR:   tt = TT_OR;
            GATE_NAND: tt = TT_NAND;
            GATE_NOR:  tt = TT_NOR;
            GATE_XOR:  tt = TT_XOR;
            GATE_XNOR: tt = TT_XNOR;
            default:   tt = 8'h00;
        endcase
        return tt;
    endfunction

    function automatic logic is_valid_sel(gate_sel_t sel);
        return sel <= GATE_XNOR;
    endfunction

endpackage

// File: rtl/three_input_gate_eval.sv
// Combinational evaluation of all six three-input gate functions.
module three_input_gate_eval
    import ic_tester_pkg::*;
(
    input  logic [NUM_IN-1:0]   abc,
    output logic [NUM_GATE-1:0] gates
);

    logic and3;
    logic or3;
    logic xor3;

    always_comb begin
        and3 = &abc;
        or3  = |abc;
        xor3 = ^abc;
        // Ordered {XNOR, XOR, NOR, NAND, OR, AND}, bit0 = AND.
        gates = {~xor3, xor3, ~or3, ~and3, or3, and3};
    end

endmodule

// File: rtl/gate_ref_select.sv
// Golden-reference gate evaluator: selects one of six gates and registers the
// selected output, its full truth table, a code-valid flag and all raw outputs.
module gate_ref_select
    import ic_tester_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [NUM_IN-1:0]   pattern,
    input  logic [2:0]          gate_select,
    output logic                y,
    output logic [7:0]          truth_table,
    output logic                sel_valid,
    output logic [NUM_GATE-1:0] y_all
);

    logic [NUM_GATE-1:0] gates;
    logic                y_d;
    logic [7:0]          tt_d;
    logic                valid_d;
    logic                y_q;
    logic [7:0]          tt_q;
    logic                valid_q;
    logic [NUM_GATE-1:0] y_all_q;

    three_input_gate_eval u_eval (
        .abc   (pattern),
        .gates (gates)
    );

    always_comb begin
        y_d     = 1'b0;
        valid_d = is_valid_sel(gate_select);
        tt_d    = truth_table_of(gate_select);
        // Undefined codes fall through with y forced low.
        if (valid_d) begin
            y_d = gates[gate_select];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q     <= 1'b0;
            tt_q    <= 8'h00;
            valid_q <= 1'b0;
            y_all_q <= '0;
        end else if (en) begin
            y_q     <= y_d;
            tt_q    <= tt_d;
            valid_q <= valid_d;
            y_all_q <= gates;
        end
    end

    assign y           = y_q;
    assign truth_table = tt_q;
    assign sel_valid   = valid_q;
    assign y_all       = y_all_q;

endmodule

// File: tb/tb_gate_ref_select.sv
// Self-checking bench for gate_ref_select against a counting-based gate model.
module tb_gate_ref_select;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] pattern = 3'd0;
    logic [2:0] gate_select = 3'd0;
    logic       y;
    logic [7:0] truth_table;
    logic       sel_valid;
    logic [5:0] y_all;

    int checks = 0;
    int failures = 0;

    logic       exp_y;
    logic [7:0] exp_tt;
    logic       exp_valid;
    logic [5:0] exp_all;

    gate_ref_select dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pattern     (pattern),
        .gate_select (gate_select),
        .y           (y),
        .truth_table (truth_table),
        .sel_valid   (sel_valid),
        .y_all       (y_all)
    );

    always #5 clk = ~clk;

    // Gate g in output order 0..5 = AND, OR, NAND, NOR, XOR, XNOR, from the count of ones.
    function automatic logic gate_fn(int g, logic [2:0] p);
        int n;
        n = int'(p[0]) + int'(p[1]) + int'(p[2]);
        case (g)
            0: return n == 3;
            1: return n > 0;
            2: return n != 3;
            3: return n == 0;
            4: return (n % 2) == 1;
            5: return (n % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Code-to-gate mapping happens to be identity for 0..5.
    task automatic model_update(logic [2:0] code, logic [2:0] p);
        logic [2:0] idx;
        exp_valid = (code < 3'd6);
        exp_y = exp_valid ? gate_fn(int'(code), p) : 1'b0;
        exp_tt = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            if (exp_valid) exp_tt[i] = gate_fn(int'(code), idx);
        end
        for (int g = 0; g < 6; g++) exp_all[g] = gate_fn(g, p);
    endtask

    task automatic model_reset();
        exp_y = 1'b0;
        exp_tt = 8'h00;
        exp_valid = 1'b0;
        exp_all = 6'd0;
    endtask

    task automatic check_outputs(string tag);
        checks += 4;
        assert (y === exp_y) else begin
            failures++;
            $error("FAIL %s y got=%0b exp=%0b", tag, y, exp_y);
        end
        assert (truth_table === exp_tt) else begin
            failures++;
            $error("FAIL %s truth_table got=%h exp=%h", tag, truth_table, exp_tt);
        end
        assert (sel_valid === exp_valid) else begin
            failures++;
            $error("FAIL %s sel_valid got=%0b exp=%0b", tag, sel_valid, exp_valid);
        end
        assert (y_all === exp_all) else begin
            failures++;
            $error("FAIL %s y_all got=%b exp=%b", tag, y_all, exp_all);
        end
    endtask

    // Drive on negedge, clock, then sample 1 time unit after the rising edge.
    task automatic step(logic e, logic [2:0] code, logic [2:0] p, string tag);
        @(negedge clk);
        en = e;
        gate_select = code;
        pattern = p;
        @(posedge clk);
        if (e) model_update(code, p);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, 3'b010, 3'b011, "pre_async_reset");
        // Reset asserted between edges must clear outputs without a clock edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset_mid");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 3'b000, 3'b111, "after_release_and111");
        checks++;
        assert (y === 1'b1 && truth_table === 8'h80) else begin
            failures++;
            $error("FAIL and111_literal y=%0b tt=%h exp y=1 tt=80", y, truth_table);
        end

        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 8; p++) begin
                step(1'b1, 3'(c), 3'(p), $sformatf("sweep_c%0d_p%0d", c, p));
                checks++;
                assert (y === truth_table[p]) else begin
                    failures++;
                    $error("FAIL invariant_c%0d_p%0d y=%0b exp=%0b", c, p, y, truth_table[p]);
                end
            end
        end

        step(1'b1, 3'b110, 3'b101, "undef_110");
        step(1'b1, 3'b111, 3'b101, "undef_111");

        step(1'b1, 3'b100, 3'b001, "hold_setup");
        for (int k = 0; k < 5; k++) step(1'b0, 3'b000, 3'b000, $sformatf("hold_%0d", k));
        step(1'b1, 3'b000, 3'b000, "hold_release");

        for (int k = 0; k < 16; k++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $sformatf("b2b_%0d", k));
        end
        for (int k = 0; k < 24; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $sformatf("rand_en_%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
